axis_sample_packer: RTL and testbench
=====================================

AXIS_SAMPLE_PACKER -- requirements
Module: axis_sample_packer

Interface
REQ-001 Parameter C_S00_AXIS_TDATA_WIDTH, default 32, input sample width; only 32 is supported.
REQ-002 Parameter C_M00_AXIS_TDATA_WIDTH, default 64, output word width; SHALL equal 2x input width.
REQ-003 Parameter FRAME_WORDS, default 256, number of output words per frame; legal range 2..65535.
REQ-004 s00_axis_aclk  input  1  single clock for all logic.
REQ-005 s00_axis_areset  input  1  reset; synchronous, active-high.
REQ-006 s00_axis_tvalid / s00_axis_tready / s00_axis_tlast  input/output/input  1 each  slave handshake and end-of-burst marker.
REQ-007 s00_axis_tdata  input  32  filter output sample.
REQ-008 s00_axis_tstrb  input  4  ignored.
REQ-009 m00_axis_tvalid / m00_axis_tready / m00_axis_tlast  output/input/output  1 each  master handshake and end-of-frame marker.
REQ-010 m00_axis_tdata  output  64  packed word.
REQ-011 m00_axis_tstrb  output  8  byte strobe.
REQ-012 frames_sent  output  16  count of output beats sent with tlast=1; wraps from 0xFFFF to 0.

Function
REQ-013 The first sample of a pair SHALL go to tdata[31:0] and the second to tdata[63:32].
REQ-014 Packing FSM states:
- PK_EMPTY: no half held. An accepted beat without tlast latches the low half and moves to PK_HALF. An accepted beat with tlast emits a partial word and stays in PK_EMPTY.
- PK_HALF: the next accepted beat completes the word and returns to PK_EMPTY.
REQ-015 Partial word: tdata[63:32]=0, tstrb=8'h0F, tlast=1.
REQ-016 Full word: tstrb=8'hFF.
REQ-017 m00_axis_tlast SHALL be 1 when either condition holds:
- the completing input beat carried tlast, or
- word_cnt==FRAME_WORDS-1.
REQ-018 word_cnt SHALL increment on each word produced and clear to 0 on each word produced with tlast=1.
REQ-019 Output path SHALL be a 2-entry skid buffer. s00_axis_tready SHALL be registered and equal to "skid entry free"; there is no combinational tready-to-tready path.
REQ-020 Once m00_axis_tvalid=1, m00_axis_tdata, tstrb and tlast SHALL hold stable until m00_axis_tready=1.
REQ-021 Latency: a completed word SHALL appear at m00 one cycle after the accepting s00 handshake.
REQ-022 Throughput with m00_axis_tready held at 1: s00 SHALL accept every cycle, i.e. one output word per two input beats, with no bubbles.
REQ-023 Simultaneous m00 handshake and new word production in one cycle SHALL neither lose nor duplicate a word.
REQ-024 Backpressure: while both skid entries are full, s00_axis_tready=0, and any held half-sample SHALL be retained.
REQ-025 frames_sent SHALL increment on each m00 handshake with tlast=1.

Reset
REQ-026 While s00_axis_areset=1 at a clock edge, the following SHALL hold the next cycle:
- m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, m00_axis_tstrb=0;
- s00_axis_tready=0, frames_sent=0, word_cnt=0, FSM=PK_EMPTY, skid entries empty.
REQ-027 s00_axis_tready SHALL rise the first cycle after reset deasserts.
REQ-028 Reset mid-frame SHALL discard any held half-sample and all buffered words; nothing is emitted afterwards from pre-reset data.

Structure
REQ-029 Package axis_pack_pkg SHALL hold:
- pack_state_t enum {PK_EMPTY, PK_HALF};
- constants STRB_FULL=8'hFF and STRB_HALF=8'h0F.
REQ-030 The skid buffer SHALL be sub-module axis_skid_buffer, parameterized on payload width (64+8+1).
REQ-031 FSM, word_cnt and frames_sent SHALL live in the top-level module.

Verification
REQ-032 Input 0x11111111, 0x22222222 with m00_axis_tready=1 -> one beat: tdata=0x2222222211111111, tstrb=0xFF, tlast=0, appearing one cycle after the second handshake.
REQ-033 Three beats A, B, C with tlast on C -> two beats: {B,A} tlast=0 tstrb=0xFF, then {0,C} tlast=1 tstrb=0x0F; frames_sent=1.
REQ-034 FRAME_WORDS=4, 16 beats continuous, no input tlast -> tlast=1 on output beats 4 and 8; frames_sent=2; zero idle cycles on s00.
REQ-035 Random m00_axis_tready (50%) over 1000 incrementing samples -> output stream equals packed input in order; no drops; tdata stable while stalled.
REQ-036 Assert reset after 3 beats (PK_HALF with one held sample), then send 0xA, 0xB -> only {0xB,0xA} is emitted; frames_sent=0.
REQ-037 m00_axis_tready=0 for 20 cycles under continuous input -> s00_axis_tready falls after the skid buffer fills; on release, all words emerge in order.

Source files
------------

// File: rtl/axis_pack_pkg.sv
// Shared types and constants for the AXI-Stream sample packer.
// Pairs of 32-bit samples are packed into 64-bit output words.
package axis_pack_pkg;

    typedef enum logic {
        PK_EMPTY,
        PK_HALF
    } pack_state_t;

    localparam logic [7:0] STRB_FULL = 8'hFF;
    localparam logic [7:0] STRB_HALF = 8'h0F;

    localparam int unsigned WORD_W = 64;

    typedef struct packed {
        logic              last;
        logic [7:0]        strb;
        logic [WORD_W-1:0] data;
    } out_word_t;

    localparam int unsigned OUT_WORD_BITS = $bits(out_word_t);

endpackage

// File: rtl/axis_sample_packer_if.sv
// AXI-Stream bus bundle; the master drives payload and valid, the slave drives ready.
interface axis_sample_packer_if #(
    parameter int unsigned DATA_W = 32
) ();

    localparam int unsigned STRB_W = DATA_W / 8;

    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;
    logic [STRB_W-1:0] tstrb;

    modport master (
        output tvalid,
        output tlast,
        output tdata,
        output tstrb,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tlast,
        input  tdata,
        input  tstrb,
        output tready
    );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry output buffer with a registered "entry free" ready.
// head_q always presents the oldest word; skid_q holds the second one.
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 73
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q, ready_d;
    logic             wr;
    logic             pop;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        wr      = in_valid && ready_q;
        pop     = (count_q != 2'd0) && out_ready;
        case (count_q)
            2'd0: begin
                if (wr) begin
                    head_d  = in_data;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (wr && pop) begin
                    head_d = in_data;
                end else if (wr) begin
                    skid_d  = in_data;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                // Ready is low whenever full, so only a pop can occur here.
                if (pop) begin
                    head_d  = skid_q;
                    count_d = 2'd1;
                end
            end
        endcase
        ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            head_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;

endmodule

// File: rtl/axis_sample_packer.sv
// Packs pairs of 32-bit input samples into 64-bit words with frame marking,
// feeding a two-entry skid buffer on the output side.
module axis_sample_packer
    import axis_pack_pkg::*;
#(
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int unsigned FRAME_WORDS            = 256
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_areset,
    axis_sample_packer_if.slave   s00_axis,
    axis_sample_packer_if.master  m00_axis,
    output logic [15:0]           frames_sent
);

    localparam logic [15:0] LAST_IDX = 16'(FRAME_WORDS - 1);

    pack_state_t                        state_q, state_d;
    logic [C_S00_AXIS_TDATA_WIDTH-1:0]  half_q, half_d;
    logic [15:0]                        word_cnt_q, word_cnt_d;
    logic [15:0]                        frames_q, frames_d;
    logic                               s_ready;
    logic                               s_hs;
    logic                               push;
    logic                               buf_valid;
    logic                               m_hs;
    out_word_t                          word_in;
    out_word_t                          word_out;
    logic                               unused_tstrb;

    assign s_hs = s00_axis.tvalid && s_ready;
    assign m_hs = buf_valid && m00_axis.tready;

    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        word_cnt_d = word_cnt_q;
        push       = 1'b0;
        word_in    = '0;
        if (state_q == PK_HALF) begin
            word_in.data = {s00_axis.tdata, half_q};
            word_in.strb = STRB_FULL;
        end else begin
            word_in.data = {{(C_M00_AXIS_TDATA_WIDTH - C_S00_AXIS_TDATA_WIDTH){1'b0}}, s00_axis.tdata};
            word_in.strb = STRB_HALF;
        end
        word_in.last = s00_axis.tlast || (word_cnt_q == LAST_IDX);

        if (s_hs) begin
            case (state_q)
                PK_EMPTY: begin
                    if (s00_axis.tlast) begin
                        push = 1'b1;
                    end else begin
                        half_d  = s00_axis.tdata;
                        state_d = PK_HALF;
                    end
                end
                PK_HALF: begin
                    push    = 1'b1;
                    state_d = PK_EMPTY;
                end
                default: state_d = PK_EMPTY;
            endcase
        end

        if (push) begin
            word_cnt_d = word_in.last ? '0 : word_cnt_q + 16'd1;
        end

        frames_d = frames_q;
        if (m_hs && word_out.last) begin
            frames_d = frames_q + 16'd1;
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state_q    <= PK_EMPTY;
            half_q     <= '0;
            word_cnt_q <= '0;
            frames_q   <= '0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            word_cnt_q <= word_cnt_d;
            frames_q   <= frames_d;
        end
    end

    // Slave ready is the buffer's registered "entry free" flag, so accepting
    // a completing beat can never overflow it.
    axis_skid_buffer #(
        .WIDTH(OUT_WORD_BITS)
    ) u_skid (
        .clk       (s00_axis_aclk),
        .rst       (s00_axis_areset),
        .in_valid  (push),
        .in_ready  (s_ready),
        .in_data   (word_in),
        .out_valid (buf_valid),
        .out_ready (m00_axis.tready),
        .out_data  (word_out)
    );

    assign s00_axis.tready = s_ready;
    assign m00_axis.tvalid = buf_valid;
    assign m00_axis.tdata  = word_out.data;
    assign m00_axis.tstrb  = word_out.strb;
    assign m00_axis.tlast  = word_out.last;
    assign frames_sent     = frames_q;
    assign unused_tstrb    = ^s00_axis.tstrb;

endmodule

// File: tb/tb_axis_sample_packer.sv
// Directed vector table plus hand-written backpressure/reset sequences.
module tb_axis_sample_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] frames_sent;
    logic        m_ready_drv = 1'b1;
    logic        rand_en = 1'b0;
    logic        rand_bit = 1'b0;

    always #5 clk = ~clk;

    axis_sample_packer_if #(.DATA_W(32)) s00_if ();
    axis_sample_packer_if #(.DATA_W(64)) m00_if ();

    assign m00_if.tready = rand_en ? rand_bit : m_ready_drv;

    axis_sample_packer #(
        .C_S00_AXIS_TDATA_WIDTH(32),
        .C_M00_AXIS_TDATA_WIDTH(64),
        .FRAME_WORDS(4)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis        (s00_if),
        .m00_axis        (m00_if),
        .frames_sent     (frames_sent)
    );

    typedef struct {
        logic [31:0] din;
        logic        din_last;
        logic        exp_valid;
        logic [63:0] exp_data;
        logic [7:0]  exp_strb;
        logic        exp_last;
    } vec_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } beat_t;

    vec_t  vecs [32];
    beat_t got_q [$];
    logic  mon_stall = 1'b0;
    beat_t mon_prev;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rand_bit = 1'($urandom_range(0, 1));
        end
    end

    // Records output handshakes and checks payload holds while stalled.
    always @(negedge clk) begin
        if (rst) begin
            mon_stall <= 1'b0;
        end else begin
            if (mon_stall) begin
                check("hold_valid", 64'(m00_if.tvalid), 64'd1);
                check("hold_data", m00_if.tdata, mon_prev.data);
                check("hold_ctl", 64'({m00_if.tstrb, m00_if.tlast}), 64'({mon_prev.strb, mon_prev.last}));
            end
            if (m00_if.tvalid && m00_if.tready)
                got_q.push_back('{m00_if.tdata, m00_if.tstrb, m00_if.tlast});
            mon_stall <= m00_if.tvalid && !m00_if.tready;
            mon_prev  <= '{m00_if.tdata, m00_if.tstrb, m00_if.tlast};
        end
    end

    task automatic do_reset();
        rst           = 1'b1;
        s00_if.tvalid = 1'b0;
        s00_if.tlast  = 1'b0;
        s00_if.tdata  = '0;
        m_ready_drv   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_tvalid", 64'(m00_if.tvalid), 64'd0);
        check("rst_m_tdata", m00_if.tdata, 64'd0);
        check("rst_m_tstrb", 64'(m00_if.tstrb), 64'd0);
        check("rst_m_tlast", 64'(m00_if.tlast), 64'd0);
        check("rst_s_tready", 64'(s00_if.tready), 64'd0);
        check("rst_frames", 64'(frames_sent), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("tready_after_rst", 64'(s00_if.tready), 64'd1);
        got_q.delete();
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        s00_if.tvalid = 1'b1;
        s00_if.tdata  = d;
        s00_if.tlast  = last;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (s00_if.tready) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: got no s00 handshake expected one within 500 cycles");
    endtask

    // Back-to-back beats; each word is checked at the negedge after its accepting edge.
    task automatic run_table(input int first, input int last_i);
        s00_if.tvalid = 1'b1;
        s00_if.tdata  = vecs[first].din;
        s00_if.tlast  = vecs[first].din_last;
        @(negedge clk);
        check("tbl_s_tready", 64'(s00_if.tready), 64'd1);
        for (int k = first; k <= last_i; k++) begin
            @(posedge clk);
            #1;
            if (k < last_i) begin
                s00_if.tdata = vecs[k+1].din;
                s00_if.tlast = vecs[k+1].din_last;
            end else begin
                s00_if.tvalid = 1'b0;
                s00_if.tlast  = 1'b0;
            end
            @(negedge clk);
            check($sformatf("tbl%0d_valid", k), 64'(m00_if.tvalid), 64'(vecs[k].exp_valid));
            if (vecs[k].exp_valid) begin
                check($sformatf("tbl%0d_data", k), m00_if.tdata, vecs[k].exp_data);
                check($sformatf("tbl%0d_strb", k), 64'(m00_if.tstrb), 64'(vecs[k].exp_strb));
                check($sformatf("tbl%0d_last", k), 64'(m00_if.tlast), 64'(vecs[k].exp_last));
            end
            if (k < last_i)
                check("tbl_s_tready", 64'(s00_if.tready), 64'd1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          acc;
        logic        hs;
        logic [63:0] exp_word;

        vecs[0]  = '{32'h1111_1111, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0};
        vecs[1]  = '{32'h2222_2222, 1'b0, 1'b1, 64'h2222_2222_1111_1111, 8'hFF, 1'b0};
        vecs[2]  = '{32'hAAAA_0001, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0};
        vecs[3]  = '{32'hBBBB_0002, 1'b0, 1'b1, 64'hBBBB_0002_AAAA_0001, 8'hFF, 1'b0};
        vecs[4]  = '{32'hCCCC_0003, 1'b1, 1'b1, 64'h0000_0000_CCCC_0003, 8'h0F, 1'b1};
        vecs[5]  = '{32'h0000_000D, 1'b1, 1'b1, 64'h0000_0000_0000_000D, 8'h0F, 1'b1};
        vecs[6]  = '{32'hE000_0000, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0};
        vecs[7]  = '{32'hE000_0001, 1'b0, 1'b1, 64'hE000_0001_E000_0000, 8'hFF, 1'b0};
        vecs[8]  = '{32'hE000_0002, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0};
        vecs[9]  = '{32'hE000_0003, 1'b0, 1'b1, 64'hE000_0003_E000_0002, 8'hFF, 1'b0};
        vecs[10] = '{32'hE000_0004, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0};
        vecs[11] = '{32'hE000_0005, 1'b0, 1'b1, 64'hE000_0005_E000_0004, 8'hFF, 1'b0};
        vecs[12] = '{32'hE000_0006, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0};
        vecs[13] = '{32'hE000_0007, 1'b0, 1'b1, 64'hE000_0007_E000_0006, 8'hFF, 1'b1};
        vecs[14] = '{32'hF000_0000, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0};
        vecs[15] = '{32'hF000_0001, 1'b1, 1'b1, 64'hF000_0001_F000_0000, 8'hFF, 1'b1};
        for (int i = 0; i < 16; i++) begin
            vecs[16+i].din       = 32'h1000_0000 + 32'(i);
            vecs[16+i].din_last  = 1'b0;
            vecs[16+i].exp_valid = (i % 2 == 1);
            vecs[16+i].exp_data  = {32'h1000_0000 + 32'(i), 32'h1000_0000 + 32'(i - 1)};
            vecs[16+i].exp_strb  = 8'hFF;
            vecs[16+i].exp_last  = (i == 7) || (i == 15);
        end

        s00_if.tstrb = 4'hF;
        do_reset();

        run_table(0, 15);
        check("frames_tbl", 64'(frames_sent), 64'd4);

        do_reset();
        run_table(16, 31);
        check("frames_4word", 64'(frames_sent), 64'd2);

        // Reset while one sample is held; only post-reset data may emerge.
        do_reset();
        send_beat(32'h0000_0001, 1'b0);
        send_beat(32'h0000_0002, 1'b0);
        send_beat(32'h0000_0003, 1'b0);
        s00_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_words", 64'(got_q.size()), 64'd1);
        do_reset();
        send_beat(32'h0000_000A, 1'b0);
        send_beat(32'h0000_000B, 1'b0);
        s00_if.tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() >= 1) begin
            check("midrst_data", got_q[0].data, 64'h0000_000B_0000_000A);
            check("midrst_ctl", 64'({got_q[0].strb, got_q[0].last}), 64'({8'hFF, 1'b0}));
        end
        check("midrst_frames", 64'(frames_sent), 64'd0);

        // Output stalled for 20 cycles under continuous input.
        do_reset();
        m_ready_drv   = 1'b0;
        acc           = 0;
        s00_if.tvalid = 1'b1;
        s00_if.tlast  = 1'b0;
        s00_if.tdata  = 32'h3000_0000;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            hs = s00_if.tready;
            @(posedge clk);
            #1;
            if (hs) begin
                acc++;
                s00_if.tdata = 32'h3000_0000 + 32'(acc);
            end
        end
        check("bp_accepted", 64'(acc), 64'd4);
        check("bp_s_tready", 64'(s00_if.tready), 64'd0);
        check("bp_head", m00_if.tdata, 64'h3000_0001_3000_0000);
        m_ready_drv = 1'b1;
        for (int c = 0; c < 100 && acc < 8; c++) begin
            @(negedge clk);
            hs = s00_if.tready;
            @(posedge clk);
            #1;
            if (hs) begin
                acc++;
                s00_if.tdata = 32'h3000_0000 + 32'(acc);
            end
        end
        s00_if.tvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_count", 64'(got_q.size()), 64'd4);
        for (int j = 0; j < 4 && j < got_q.size(); j++) begin
            exp_word = {32'h3000_0000 + 32'(2*j + 1), 32'h3000_0000 + 32'(2*j)};
            check($sformatf("bp_word%0d", j), got_q[j].data, exp_word);
            check($sformatf("bp_last%0d", j), 64'(got_q[j].last), 64'(j == 3));
        end
        check("bp_frames", 64'(frames_sent), 64'd1);

        // Random output ready over 1000 incrementing samples.
        do_reset();
        rand_en = 1'b1;
        for (int i = 0; i < 1000; i++)
            send_beat(32'h5000_0000 + 32'(i), 1'b0);
        s00_if.tvalid = 1'b0;
        for (int c = 0; c < 3000 && got_q.size() < 500; c++) begin
            @(posedge clk);
            #1;
        end
        rand_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rnd_count", 64'(got_q.size()), 64'd500);
        for (int j = 0; j < 500 && j < got_q.size(); j++) begin
            exp_word = {32'h5000_0000 + 32'(2*j + 1), 32'h5000_0000 + 32'(2*j)};
            check($sformatf("rnd_word%0d", j), got_q[j].data, exp_word);
            check($sformatf("rnd_ctl%0d", j), 64'({got_q[j].strb, got_q[j].last}),
                  64'({8'hFF, (j % 4 == 3)}));
        end
        check("rnd_frames", 64'(frames_sent), 64'd125);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
